// File: rtl/seq_divider_16bits_pkg.sv
// seq_divider_16bits_pkg: widths, FSM encodings and divide-by-zero constants for the sequential divider
package seq_divider_16bits_pkg;
    localparam int WIDTH = 16;
    localparam int CNT_W = 5;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [WIDTH-1:0] DBZ_QUOTIENT = 16'hFFFF;
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);
endpackage

// File: rtl/seq_divider_16bits_adder.sv
// adder_16bits: 16-bit ripple add/sub; ctr=1 subtracts (a - b) and co is then the not-borrow flag
module adder_16bits
    import seq_divider_16bits_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ctr,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    logic [WIDTH:0] c;
    assign c[0] = ctr;
    assign co = c[WIDTH];
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic bx;
        assign bx = b[i] ^ ctr;
        assign s[i] = a[i] ^ bx ^ c[i];
        assign c[i+1] = (a[i] & bx) | (c[i] & (a[i] ^ bx));
    end
endmodule

// File: rtl/seq_divider_16bits.sv
// seq_divider_16bits: unsigned restoring divider, one quotient bit per clock, start/done handshake
module seq_divider_16bits
    import seq_divider_16bits_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    logic [1:0] state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q, r, d, s, r_next, q_next;
    logic [WIDTH:0] t;
    logic co, ok;

    assign t = {r, q[WIDTH-1]};
    adder_16bits u_sub (.a(t[WIDTH-1:0]), .b(d), .ctr(1'b1), .s(s), .co(co));
    // T[16] set means T >= 2^16 > D, so the subtraction is always taken
    assign ok = t[WIDTH] | co;
    assign r_next = ok ? s : t[WIDTH-1:0];
    assign q_next = {q[WIDTH-2:0], ok};
    assign busy = state == S_RUN;
    assign done = state == S_DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt <= '0;
            q <= '0;
            r <= '0;
            d <= '0;
            quotient <= '0;
            remainder <= '0;
            div_by_zero <= 1'b0;
        end else if (state == S_RUN) begin
            q <= q_next;
            r <= r_next;
            cnt <= cnt + 1'b1;
            if (cnt == ITER_LAST) begin
                state <= S_DONE;
                quotient <= q_next;
                remainder <= r_next;
            end
        end else if (start) begin
            d <= divisor;
            q <= dividend;
            r <= '0;
            cnt <= '0;
            div_by_zero <= divisor == '0;
            state <= divisor == '0 ? S_DONE : S_RUN;
            if (divisor == '0) begin
                quotient <= DBZ_QUOTIENT;
                remainder <= dividend;
            end
        end else begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_seq_divider_16bits.sv
// tb_seq_divider_16bits: directed scoreboard bench for the sequential divider
module tb_seq_divider_16bits;
    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic busy, done, div_by_zero;
    logic [15:0] quotient, remainder;
    int checks = 0;
    int errors = 0;
    res_t sb[$];

    seq_divider_16bits dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // called at a negedge; start is seen by the next rising edge, returns at the following negedge
    task automatic do_start(input logic [15:0] a, input logic [15:0] b);
        res_t e;
        e.q = (b == 0) ? 16'hFFFF : a / b;
        e.r = (b == 0) ? a : a % b;
        e.z = (b == 0);
        sb.push_back(e);
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int n;
        res_t e;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
        e = sb.pop_front();
        chk({tag, "_q"}, {16'd0, quotient}, {16'd0, e.q});
        chk({tag, "_r"}, {16'd0, remainder}, {16'd0, e.r});
        chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.z});
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", {16'd0, quotient}, 32'd0);
        chk("rst_r", {16'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        do_start(16'd100, 16'd7);
        chk("d100_busy_c1", {31'd0, busy}, 32'd1);
        repeat (15) @(negedge clk);
        chk("d100_busy_c16", {31'd0, busy}, 32'd1);
        chk("d100_done_c16", {31'd0, done}, 32'd0);
        wait_done("d100", 1);
        repeat (3) @(negedge clk);
        chk("hold_q", {16'd0, quotient}, 32'd14);
        chk("hold_done", {31'd0, done}, 32'd0);
        do_start(16'hFFFF, 16'h0001);
        wait_done("ffff_1", 16);
        @(negedge clk);
        do_start(16'hFFFF, 16'hFFFF);
        wait_done("ffff_ffff", 16);
        @(negedge clk);
        do_start(16'h8000, 16'h8001);
        wait_done("t16", 16);
        @(negedge clk);
        do_start(16'd5, 16'd0);
        wait_done("dbz", 0);
        @(negedge clk);
        do_start(16'd200, 16'd9);
        wait_done("dbz_clear", 16);
        @(negedge clk);
        do_start(16'd1000, 16'd3);
        repeat (4) @(negedge clk);
        dividend = 16'd3;
        divisor = 16'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored", 11);
        do_start(16'd50, 16'd8);
        wait_done("b2b", 16);
        @(negedge clk);
        do_start(16'd1000, 16'd7);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_q", {16'd0, quotient}, 32'd0);
        chk("mid_rst_r", {16'd0, remainder}, 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen += int'(done);
        end
        chk("mid_rst_no_done", seen, 0);
        do_start(16'd9, 16'd3);
        wait_done("d9", 16);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
